// File: rtl/nivel_hambre_gen.sv
// Hunger level generator: decays one step per DECAY_SECS, rises per debounced feed press.
// Build option: define MODO_TEST_EN for fast simulation (no prescaler, 1-cycle debounce).
module nivel_hambre_gen #(
  parameter int unsigned TICKS_PER_SEC   = 50_000_000,
  parameter int unsigned DECAY_SECS      = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Boton_Comida,
  input  logic       Pausa,
  output logic [1:0] Nivel,
  output logic       Pulso_Comida,
  output logic       Nivel_Cero,
  output logic [1:0] o_estado_dbg
);

  // Debug encoding of o_estado_dbg: 0 ESPERA, 1 FILTRO, 2 PRESIONADO, 3 LIBERACION.
  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    FILTRO     = 2'd1,
    PRESIONADO = 2'd2,
    LIBERACION = 2'd3
  } estado_t;

`ifdef MODO_TEST_EN
  localparam int unsigned DB_CYC    = 1;
  localparam bit          DB_BYPASS = 1'b1;
`else
  localparam int unsigned DB_CYC    = DEBOUNCE_CYCLES;
  localparam bit          DB_BYPASS = 1'b0;
`endif

  localparam int unsigned DB_W  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int unsigned DEC_W = (DECAY_SECS > 1) ? $clog2(DECAY_SECS) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_SECS - 1);

  logic            r_sync1, r_sync2;
  logic            w_btn;
  estado_t         r_est, w_est_next;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_db_clr, w_db_inc, w_accept;

  logic             w_tick, w_wrap;
  logic [DEC_W-1:0] r_dec;
  logic [1:0]       r_nivel, w_nivel_next;
  logic             r_pulso, r_cero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= Boton_Comida;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_est    <= ESPERA;
      r_db_cnt <= '0;
    end else begin
      r_est <= w_est_next;
      if (w_db_clr)      r_db_cnt <= '0;
      else if (w_db_inc) r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // A held button parks in PRESIONADO, so only the FILTRO exit can accept.
  always_comb begin
    w_est_next = r_est;
    w_db_clr   = 1'b0;
    w_db_inc   = 1'b0;
    w_accept   = 1'b0;
    case (r_est)
      ESPERA: begin
        if (w_btn) begin
          if (DB_BYPASS) begin
            w_est_next = PRESIONADO;
            w_accept   = 1'b1;
          end else begin
            w_est_next = FILTRO;
            w_db_clr   = 1'b1;
          end
        end
      end
      FILTRO: begin
        if (!w_btn) begin
          w_est_next = ESPERA;
        end else if (r_db_cnt == DB_LAST) begin
          w_est_next = PRESIONADO;
          w_accept   = 1'b1;
        end else begin
          w_db_inc = 1'b1;
        end
      end
      PRESIONADO: begin
        if (!w_btn) begin
          w_est_next = LIBERACION;
          w_db_clr   = 1'b1;
        end
      end
      LIBERACION: begin
        if (w_btn) begin
          w_est_next = PRESIONADO;
        end else if (r_db_cnt == DB_LAST) begin
          w_est_next = ESPERA;
        end else begin
          w_db_inc = 1'b1;
        end
      end
      default: w_est_next = ESPERA;
    endcase
  end

`ifdef MODO_TEST_EN
  assign w_tick = ~Pausa;
`else
  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] r_pre;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_accept) begin
      r_pre <= '0;
    end else if (!Pausa) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
    end
  end

  assign w_tick = !Pausa && (r_pre == PRE_LAST);
`endif

  assign w_wrap = w_tick && (r_dec == DEC_LAST);

  // A feed in the same cycle as a decay wrap wins; the decay is dropped.
  always_comb begin
    w_nivel_next = r_nivel;
    if (w_accept) begin
      if (r_nivel != 2'd3) w_nivel_next = r_nivel + 2'd1;
    end else if (w_wrap) begin
      if (r_nivel != 2'd0) w_nivel_next = r_nivel - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec   <= '0;
      r_nivel <= 2'd3;
      r_pulso <= 1'b0;
      r_cero  <= 1'b0;
    end else begin
      if (w_accept)    r_dec <= '0;
      else if (w_tick) r_dec <= w_wrap ? '0 : r_dec + 1'b1;
      r_nivel <= w_nivel_next;
      r_pulso <= w_accept;
      r_cero  <= (w_nivel_next == 2'd0);
    end
  end

  assign Nivel        = r_nivel;
  assign Pulso_Comida = r_pulso;
  assign Nivel_Cero   = r_cero;
  assign o_estado_dbg = r_est;

endmodule

// File: tb/tb_nivel_hambre_gen.sv
// Directed bench for nivel_hambre_gen with TICKS_PER_SEC=4, DECAY_SECS=3, DEBOUNCE_CYCLES=2.
// Edge numbers in comments count rising clock edges since reset release.
module tb_nivel_hambre_gen;

  localparam logic [7:0] ST_ESPERA     = 8'd0;
  localparam logic [7:0] ST_FILTRO     = 8'd1;
  localparam logic [7:0] ST_PRESIONADO = 8'd2;

  logic       clk;
  logic       reset;
  logic       boton;
  logic       pausa;
  logic [1:0] nivel;
  logic       pulso;
  logic       cero;
  logic [1:0] estado;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulsos = 0;
  int edge_n   = 0;

  // Scoreboard: expected accept count per press window.
  logic [7:0] exp_q[$];

  nivel_hambre_gen #(
    .TICKS_PER_SEC  (4),
    .DECAY_SECS     (3),
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Boton_Comida(boton),
    .Pausa       (pausa),
    .Nivel       (nivel),
    .Pulso_Comida(pulso),
    .Nivel_Cero  (cero),
    .o_estado_dbg(estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (pulso === 1'b1) n_pulsos++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic abrir_ventana(input logic [7:0] esperados);
    n_pulsos = 0;
    exp_q.push_back(esperados);
  endtask

  task automatic cerrar_ventana(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    chk(tag, 8'(n_pulsos), exp);
  endtask

  task automatic chk_nivel(input string tag, input logic [1:0] exp_n, input logic exp_c);
    chk({tag, "_nivel"}, {6'd0, nivel}, {6'd0, exp_n});
    chk({tag, "_cero"}, {7'd0, cero}, {7'd0, exp_c});
  endtask

  initial begin
    reset = 1'b0;
    boton = 1'b0;
    pausa = 1'b0;
    ciclos(3);
    chk_nivel("reset", 2'd3, 1'b0);
    chk("reset_pulso", {7'd0, pulso}, 8'd0);
    chk("reset_estado", {6'd0, estado}, ST_ESPERA);
    reset  = 1'b1;
    edge_n = 0;

    // Idle decay: one step every 12 edges, saturating at 0.
    ciclos(11); chk_nivel("decay_e11", 2'd3, 1'b0);
    ciclos(1);  chk_nivel("decay_e12", 2'd2, 1'b0);
    ciclos(23); chk_nivel("decay_e35", 2'd1, 1'b0);
    ciclos(1);  chk_nivel("decay_e36", 2'd0, 1'b1);
    ciclos(12); chk_nivel("decay_e48", 2'd0, 1'b1);

    // Press A: accepted 5 edges after the button rises (2 sync + 3 filter).
    abrir_ventana(8'd1);
    boton = 1'b1;
    ciclos(4);
    boton = 1'b0;
    ciclos(1);
    chk("feedA_pulso", {7'd0, pulso}, 8'd1);
    chk_nivel("feedA", 2'd1, 1'b0);
    ciclos(4);
    chk("feedA_estado", {6'd0, estado}, ST_ESPERA);
    cerrar_ventana("feedA_npulsos");

    // Press B held 20 edges at level 1, bounce on release.
    abrir_ventana(8'd1);
    boton = 1'b1;
    ciclos(5);
    chk("feedB_pulso", {7'd0, pulso}, 8'd1);
    chk_nivel("feedB", 2'd2, 1'b0);
    ciclos(11); chk_nivel("feedB_e73", 2'd2, 1'b0);
    ciclos(1);  chk_nivel("feedB_e74", 2'd1, 1'b0);
    ciclos(3);
    boton = 1'b0;
    ciclos(1);
    boton = 1'b1;
    ciclos(1);
    boton = 1'b0;
    ciclos(2);
    chk("bounce_estado", {6'd0, estado}, ST_PRESIONADO);
    ciclos(3);
    chk("bounce_fin_estado", {6'd0, estado}, ST_ESPERA);
    cerrar_ventana("feedB_npulsos");

    // One-edge glitch: enters FILTRO, falls back, no feed; decay at edge 86 still happens.
    abrir_ventana(8'd0);
    boton = 1'b1;
    ciclos(1);
    boton = 1'b0;
    chk_nivel("glitch_e85", 2'd1, 1'b0);
    ciclos(2);
    chk("glitch_filtro", {6'd0, estado}, ST_FILTRO);
    chk_nivel("glitch_e87", 2'd0, 1'b1);
    ciclos(1);
    chk("glitch_espera", {6'd0, estado}, ST_ESPERA);
    ciclos(3);
    cerrar_ventana("glitch_npulsos");

    // Press C and D bring level from 0 to 2.
    abrir_ventana(8'd2);
    boton = 1'b1;
    ciclos(3);
    boton = 1'b0;
    ciclos(2);
    chk_nivel("feedC", 2'd1, 1'b0);
    ciclos(3);
    boton = 1'b1;
    ciclos(3);
    boton = 1'b0;
    ciclos(2);
    chk_nivel("feedD", 2'd2, 1'b0);
    ciclos(3);
    cerrar_ventana("feedCD_npulsos");

    // Press E lands on the decay wrap at edge 116: feed wins.
    ciclos(4);
    abrir_ventana(8'd1);
    boton = 1'b1;
    ciclos(3);
    boton = 1'b0;
    ciclos(1);
    chk_nivel("wrap_e115", 2'd2, 1'b0);
    chk("wrap_e115_pulso", {7'd0, pulso}, 8'd0);
    ciclos(1);
    chk_nivel("wrap_e116", 2'd3, 1'b0);
    chk("wrap_e116_pulso", {7'd0, pulso}, 8'd1);
    ciclos(3);
    cerrar_ventana("wrap_npulsos");

    // Press F at level 3: still pulses, level stays 3, decay restarts.
    abrir_ventana(8'd1);
    boton = 1'b1;
    ciclos(3);
    boton = 1'b0;
    ciclos(2);
    chk_nivel("sat_e124", 2'd3, 1'b0);
    chk("sat_pulso", {7'd0, pulso}, 8'd1);
    ciclos(3);
    cerrar_ventana("sat_npulsos");
    ciclos(8);  chk_nivel("sat_e135", 2'd3, 1'b0);
    ciclos(1);  chk_nivel("sat_e136", 2'd2, 1'b0);

    // Pause 40 edges with 7 edges left to the next decay.
    ciclos(5);
    pausa = 1'b1;
    ciclos(40); chk_nivel("pausa_fin", 2'd2, 1'b0);
    pausa = 1'b0;
    ciclos(6);  chk_nivel("pausa_e187", 2'd2, 1'b0);
    ciclos(1);  chk_nivel("pausa_e188", 2'd1, 1'b0);

    // Reset while filtering aborts the press; no pulse after release.
    abrir_ventana(8'd0);
    boton = 1'b1;
    ciclos(3);
    chk("rst_pre_estado", {6'd0, estado}, ST_FILTRO);
    reset = 1'b0;
    #1;
    chk_nivel("rst_async", 2'd3, 1'b0);
    chk("rst_async_pulso", {7'd0, pulso}, 8'd0);
    chk("rst_async_estado", {6'd0, estado}, ST_ESPERA);
    boton = 1'b0;
    ciclos(2);
    reset = 1'b1;
    ciclos(8);
    chk_nivel("rst_post", 2'd3, 1'b0);
    cerrar_ventana("rst_npulsos");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
